// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame length default,
// scheduler state encoding and the wait-counter sizing rule.
package uart_pkg;

  localparam int FRAME_CYCLES_DEF = 10;
  localparam int GAP_CYCLES_MAX   = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

  // The counter must hold the longest post-SEND wait: frame minus SEND/accept plus max gap.
  function automatic int wait_cnt_width(input int frame_cycles);
    return $clog2(frame_cycles - 2 + GAP_CYCLES_MAX + 1);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, searching upward
// from a pointer that moves past the winner on each accepted grant.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       grant_idx
);

  logic [2:0] ptr;
  logic [2:0] idx_hi;
  logic [2:0] idx_lo;
  logic       hit_hi;
  logic       hit_lo;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    hit_hi    = 1'b0;
    hit_lo    = 1'b0;
    idx_hi    = '0;
    idx_lo    = '0;
    grant     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx_lo = 3'(k);
        hit_lo = 1'b1;
        if (3'(k) >= ptr) begin
          idx_hi = 3'(k);
          hit_hi = 1'b1;
        end
      end
    end
    grant_idx = hit_hi ? idx_hi : idx_lo;
    for (int k = 0; k < N_REQ; k++) begin
      grant[k] = hit_lo && (grant_idx == 3'(k));
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (RESET) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == 3'(N_REQ - 1)) ? '0 : grant_idx + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one valid-only UART transmitter among N_REQ requesters: round-robin
// grant, single-cycle tx_valid pulse, then times frame plus gap before re-arming.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int GAP_CYCLES   = 0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               enable,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int             CW     = wait_cnt_width(FRAME_CYCLES);
  localparam int             W      = FRAME_CYCLES - 2 + GAP_CYCLES;
  localparam logic [CW-1:0]  W_LOAD = CW'(W);

  sched_state_t     state;
  sched_state_t     next_state;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] grant;
  logic [2:0]       grant_idx;
  logic             accept;
  logic [7:0]       sel_data;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept    = (state == IDLE) && enable && (|req_valid);
  assign req_ready = accept ? grant : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_data = req_data[8*k +: 8];
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = SEND;
      SEND:    next_state = (W_LOAD != '0) ? WAIT : IDLE;
      WAIT:    if (cnt == CW'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      state    <= next_state;
      tx_valid <= accept;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= grant_idx;
      end
      // Counter covers the remainder of the frame after SEND plus the idle gap.
      if (state == SEND) begin
        cnt <= W_LOAD;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule
